wb_regfile_hilo: RTL and testbench
==================================

Name: wb_regfile_hilo

Overview:
Architectural state block at the consuming end of the writeback interface. It holds the 32 general-purpose registers and the HI/LO pair, and takes the writeback-stage outputs as its write ports. It provides two combinational GPR read ports to the decode stage and HI/LO read-out to the execute stage. Same-cycle write-to-read bypass is included, so decode sees a value being written back in the same cycle.

Parameters:
DATA_W, 32, width of GPRs, HI and LO
ADDR_W, 5, GPR address width
NUM_REGS, 32, number of GPRs (2**ADDR_W)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
wb_wReg  input  1  GPR write enable from writeback
wb_wAddr  input  ADDR_W  GPR write address
wb_wData  input  DATA_W  GPR write data
wb_wHiLo  input  1  HI/LO write enable from writeback
wb_hiData  input  DATA_W  HI write data
wb_loData  input  DATA_W  LO write data
re1  input  1  read port 1 enable
raddr1  input  ADDR_W  read port 1 address
rdata1  output  DATA_W  read port 1 data
re2  input  1  read port 2 enable
raddr2  input  ADDR_W  read port 2 address
rdata2  output  DATA_W  read port 2 data
hi_o  output  DATA_W  current HI, bypassed
lo_o  output  DATA_W  current LO, bypassed

Behaviour:
- Reset: clk and rst only; rst is synchronous, active-high.
  - On a rising edge with rst=1, all GPRs, HI and LO become 0.
  - Writes presented in that cycle are discarded.
  - While rst=1, rdata1, rdata2, hi_o and lo_o are forced to 0 combinationally.
- GPR write: on a rising edge with rst=0, wb_wReg=1 and wb_wAddr!=0, the register at wb_wAddr takes wb_wData.
- Register 0:
  - Writes to address 0 are ignored.
  - It always reads 0.
- Read ports: combinational, zero latency. Priority per port, highest first:
  1. rst=1 -> 0
  2. reN=0 -> 0
  3. raddrN=0 -> 0
  4. wb_wReg=1 and wb_wAddr==raddrN -> wb_wData (write-through bypass)
  5. otherwise the stored register value
- Dual-port reads: both ports may read the same address simultaneously. Both may bypass from the single write port in the same cycle.
- HI/LO write:
  - On a rising edge with rst=0 and wb_wHiLo=1, HI takes wb_hiData and LO takes wb_loData.
  - HI and LO are always written together; there is no partial write.
- HI/LO read-out:
  - hi_o = wb_hiData if wb_wHiLo=1, else stored HI. lo_o follows the same rule with wb_loData.
  - Forced to 0 during rst.
- Independence: GPR and HI/LO writes are independent and may occur in the same cycle.
- No stall or flush inputs. The writeback stage presents each write for exactly one cycle, and every presented write with rst=0 is committed.
- Reset during an active write: reset wins and the write is lost.
- Width rules: all data is DATA_W bits with no sign or zero extension. Out-of-range addresses cannot occur (NUM_REGS = 2**ADDR_W).

Test Plan:
- Reset: write r5=0x1234 and HI=0xAAAA5555, then assert rst for 1 cycle and read r5 and HI -> rdata1=0, hi_o=0. With rst held high, rdata outputs stay 0.
- Write then read: write r7=0xDEADBEEF; next cycle raddr1=7, re1=1 -> rdata1=0xDEADBEEF. Same with re1=0 -> rdata1=0.
- Bypass:
  - Same cycle: wb_wReg=1, wb_wAddr=9, wb_wData=0x55; raddr1=9, raddr2=9, both enables 1 -> rdata1=rdata2=0x55 before the edge; stored value is 0x55 after the edge.
  - Variant: wb_wReg=0 with wb_wAddr=9 -> no bypass; the old value is read.
- Register 0: write r0=0xFFFFFFFF, with bypass conditions active on raddr1=0 -> rdata1=0 that cycle and all later cycles.
- HI/LO: wb_wHiLo=1, hi=0x1, lo=0x2 in the same cycle as a GPR write r3=0x3 -> hi_o=1, lo_o=2 combinationally. After the edge, HI=1, LO=2 and r3=3 with wb_wHiLo=0.
- Reset vs write collision: rst=1 together with wb_wReg=1, wb_wAddr=4, wb_wData=0x77 -> after the edge with rst=0, r4 reads 0.

Source files
------------

// File: rtl/wb_regfile_hilo_if.sv
// Writeback-to-regfile bus: GPR and HI/LO write ports in, decode read ports and HI/LO out.
// The master drives writes and read requests; the slave is the register file.
interface wb_regfile_hilo_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb_wReg;
   logic [ADDR_W-1:0] wb_wAddr;
   logic [DATA_W-1:0] wb_wData;
   logic              wb_wHiLo;
   logic [DATA_W-1:0] wb_hiData;
   logic [DATA_W-1:0] wb_loData;
   logic              re1;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata1;
   logic              re2;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata2;
   logic [DATA_W-1:0] hi_o;
   logic [DATA_W-1:0] lo_o;

   modport master (
      output wb_wReg, wb_wAddr, wb_wData, wb_wHiLo, wb_hiData, wb_loData,
      output re1, raddr1, re2, raddr2,
      input  rdata1, rdata2, hi_o, lo_o
   );

   modport slave (
      input  wb_wReg, wb_wAddr, wb_wData, wb_wHiLo, wb_hiData, wb_loData,
      input  re1, raddr1, re2, raddr2,
      output rdata1, rdata2, hi_o, lo_o
   );
endinterface

// File: rtl/wb_regfile_hilo.sv
// Architectural GPR file plus HI/LO pair, written from writeback, with same-cycle
// write-through bypass on both decode read ports and on the HI/LO read-out.
module wb_regfile_hilo #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   wb_regfile_hilo_if.slave  bus
);
   logic [DATA_W-1:0] r_gpr [NUM_REGS];
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic              w_gpr_we;
   logic [DATA_W-1:0] w_rd1_stored;
   logic [DATA_W-1:0] w_rd2_stored;

   function automatic logic [DATA_W-1:0] read_port(
      input logic              reset,
      input logic              en,
      input logic [ADDR_W-1:0] addr,
      input logic              wreg,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] res;
      if (reset || !en || (addr == '0)) begin
         res = '0;
      end else if (wreg && (waddr == addr)) begin
         res = wdata;
      end else begin
         res = stored;
      end
      return res;
   endfunction

   // r0 is never written, so it holds the zero it got at reset
   assign w_gpr_we = bus.wb_wReg && (bus.wb_wAddr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_gpr[i] <= '0;
         end
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (w_gpr_we) begin
            r_gpr[bus.wb_wAddr] <= bus.wb_wData;
         end
         if (bus.wb_wHiLo) begin
            r_hi <= bus.wb_hiData;
            r_lo <= bus.wb_loData;
         end
      end
   end

   assign w_rd1_stored = r_gpr[bus.raddr1];
   assign w_rd2_stored = r_gpr[bus.raddr2];

   always_comb begin
      bus.rdata1 = read_port(rst, bus.re1, bus.raddr1, bus.wb_wReg, bus.wb_wAddr,
                             bus.wb_wData, w_rd1_stored);
      bus.rdata2 = read_port(rst, bus.re2, bus.raddr2, bus.wb_wReg, bus.wb_wAddr,
                             bus.wb_wData, w_rd2_stored);
   end

   always_comb begin
      bus.hi_o = '0;
      bus.lo_o = '0;
      if (!rst) begin
         bus.hi_o = bus.wb_wHiLo ? bus.wb_hiData : r_hi;
         bus.lo_o = bus.wb_wHiLo ? bus.wb_loData : r_lo;
      end
   end
endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Table-driven bench for wb_regfile_hilo: each row is one cycle of inputs with the
// combinational outputs expected before that cycle's rising edge.
module tb_wb_regfile_hilo;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct {
      logic        rst;
      logic        wreg;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        re1;
      logic [4:0]  ra1;
      logic        re2;
      logic [4:0]  ra2;
      logic [31:0] exp_r1;
      logic [31:0] exp_r2;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   vec_t tbl[$];
   exp_t sb[$];

   wb_regfile_hilo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   wb_regfile_hilo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(
      input logic rs, input logic wr, input logic [4:0] wa, input logic [31:0] wd,
      input logic wh, input logic [31:0] h, input logic [31:0] l,
      input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
      input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] xh,
      input logic [31:0] xl
   );
      vec_t v;
      v.rst = rs; v.wreg = wr; v.waddr = wa; v.wdata = wd;
      v.whilo = wh; v.hi = h; v.lo = l;
      v.re1 = e1; v.ra1 = a1; v.re2 = e2; v.ra2 = a2;
      v.exp_r1 = x1; v.exp_r2 = x2; v.exp_hi = xh; v.exp_lo = xl;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one row, push its expectation, compare mid-cycle, then let the edge commit.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      exp_t got;
      rst           = v.rst;
      bus.wb_wReg   = v.wreg;
      bus.wb_wAddr  = v.waddr;
      bus.wb_wData  = v.wdata;
      bus.wb_wHiLo  = v.whilo;
      bus.wb_hiData = v.hi;
      bus.wb_loData = v.lo;
      bus.re1       = v.re1;
      bus.raddr1    = v.ra1;
      bus.re2       = v.re2;
      bus.raddr2    = v.ra2;
      e.r1 = v.exp_r1; e.r2 = v.exp_r2; e.hi = v.exp_hi; e.lo = v.exp_lo;
      sb.push_back(e);
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
      end else begin
         got = sb.pop_front();
         check({tag, " rdata1"}, bus.rdata1, got.r1);
         check({tag, " rdata2"}, bus.rdata2, got.r2);
         check({tag, " hi_o"},   bus.hi_o,   got.hi);
         check({tag, " lo_o"},   bus.lo_o,   got.lo);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus.wb_wReg = 1'b0; bus.wb_wAddr = '0; bus.wb_wData = '0;
      bus.wb_wHiLo = 1'b0; bus.wb_hiData = '0; bus.wb_loData = '0;
      bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;

      //             rst wr wa  wdata         wh hi            lo            e1 a1  e2 a2  exp_r1        exp_r2        exp_hi        exp_lo
      tbl.push_back(mk(1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 5,  32'h0,        32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(0, 1, 5,  32'h1234,     1, 32'hAAAA5555, 32'h0BAD,     1, 5,  0, 5,  32'h1234,     32'h0,        32'hAAAA5555, 32'h0BAD));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 5,  32'h1234,     32'h1234,     32'hAAAA5555, 32'h0BAD));
      tbl.push_back(mk(1, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 5,  32'h0,        32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(1, 1, 4,  32'h77,       1, 32'h99,       32'h88,       1, 4,  1, 4,  32'h0,        32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 5,  1, 4,  32'h0,        32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(0, 1, 7,  32'hDEADBEEF, 0, 32'h0,        32'h0,        1, 7,  0, 7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 7,  0, 7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(0, 1, 9,  32'h55,       0, 32'h0,        32'h0,        1, 9,  1, 9,  32'h55,       32'h55,       32'h0,        32'h0));
      tbl.push_back(mk(0, 0, 9,  32'hAA,       0, 32'h0,        32'h0,        1, 9,  1, 9,  32'h55,       32'h55,       32'h0,        32'h0));
      tbl.push_back(mk(0, 1, 0,  32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 0,  1, 9,  32'h0,        32'h55,       32'h0,        32'h0));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 0,  1, 0,  32'h0,        32'h0,        32'h0,        32'h0));
      tbl.push_back(mk(0, 1, 3,  32'h3,        1, 32'h1,        32'h2,        1, 3,  1, 7,  32'h3,        32'hDEADBEEF, 32'h1,        32'h2));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h5,        32'h6,        1, 3,  1, 9,  32'h3,        32'h55,       32'h1,        32'h2));
      tbl.push_back(mk(0, 1, 9,  32'h12345678, 1, 32'hFFFFFFFF, 32'h80000000, 0, 9,  1, 9,  32'h0,        32'h12345678, 32'hFFFFFFFF, 32'h80000000));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 9,  1, 31, 32'h12345678, 32'h0,        32'hFFFFFFFF, 32'h80000000));
      tbl.push_back(mk(0, 1, 31, 32'hCAFEF00D, 0, 32'h0,        32'h0,        1, 31, 1, 30, 32'hCAFEF00D, 32'h0,        32'hFFFFFFFF, 32'h80000000));
      tbl.push_back(mk(0, 0, 0,  32'h0,        0, 32'h0,        32'h0,        1, 31, 1, 3,  32'hCAFEF00D, 32'h3,        32'hFFFFFFFF, 32'h80000000));

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end

      // rst held for several cycles while writes and reads keep arriving
      for (int i = 0; i < 3; i++) begin
         apply(mk(1, 1, 31, 32'h11111111 * (i + 1), 1, 32'hABCD0000, 32'h0000ABCD,
                  1, 31, 1, 3, 32'h0, 32'h0, 32'h0, 32'h0), $sformatf("rsthold%0d", i));
      end
      apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 31, 1, 3,
               32'h0, 32'h0, 32'h0, 32'h0), "post_rst_a");
      apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 1, 7, 1, 9,
               32'h0, 32'h0, 32'h0, 32'h0), "post_rst_b");

      // back-to-back writes to one register: each cycle bypasses the newest value
      apply(mk(0, 1, 12, 32'hA1, 1, 32'h10, 32'h20, 1, 12, 1, 12,
               32'hA1, 32'hA1, 32'h10, 32'h20), "b2b_0");
      apply(mk(0, 1, 12, 32'hB2, 1, 32'h30, 32'h40, 1, 12, 1, 13,
               32'hB2, 32'h0, 32'h30, 32'h40), "b2b_1");
      apply(mk(0, 1, 13, 32'hC3, 0, 32'h50, 32'h60, 1, 12, 1, 13,
               32'hB2, 32'hC3, 32'h30, 32'h40), "b2b_2");
      apply(mk(0, 0, 12, 32'hDD, 0, 32'h0, 32'h0, 1, 12, 1, 13,
               32'hB2, 32'hC3, 32'h30, 32'h40), "b2b_3");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
